// File: rtl/alu_share_arbiter.sv
// Round-robin sharer of one combinational ALU between two requesters; one op in flight.
// Latency: accept -> resp_valid after 2 edges; resp_valid holds (no timeout) until owner's resp_ready.
module alu_share_arbiter #(
    parameter int data_width = 16,
    parameter int func_width = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [data_width-1:0] req_A0,
    input  logic [data_width-1:0] req_B0,
    input  logic [func_width-1:0] req_func0,
    input  logic [data_width-1:0] req_A1,
    input  logic [data_width-1:0] req_B1,
    input  logic [func_width-1:0] req_func1,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [data_width-1:0] resp_C,
    output logic [data_width-1:0] alu_A,
    output logic [data_width-1:0] alu_B,
    output logic [func_width-1:0] alu_func,
    input  logic [data_width-1:0] alu_C,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   owner;
    logic   grant;
    logic   accept;
    logic   resp_done;

    // A lone requester wins outright; prio only breaks ties.
    always_comb begin
        grant = prio;
        if (req_valid == 2'b01)
            grant = 1'b0;
        else if (req_valid == 2'b10)
            grant = 1'b1;
    end

    assign accept    = (state == IDLE) && req_valid[grant];
    assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign resp_done  = (state == RESP) && resp_ready[owner];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            alu_A    <= '0;
            alu_B    <= '0;
            alu_func <= '0;
            resp_C   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_A    <= grant ? req_A1    : req_A0;
                        alu_B    <= grant ? req_B1    : req_B0;
                        alu_func <= grant ? req_func1 : req_func0;
                        owner    <= grant;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    resp_C <= alu_C;
                    state  <= RESP;
                end
                RESP: begin
                    if (resp_done) begin
                        prio  <= ~owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural model of the shared ALU
// (func 0=AND, 1=OR, 2=XOR, 3=ADD).
module tb_alu_share_arbiter;

    localparam logic [3:0] F_AND = 4'd0;
    localparam logic [3:0] F_OR  = 4'd1;
    localparam logic [3:0] F_XOR = 4'd2;
    localparam logic [3:0] F_ADD = 4'd3;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_A0, req_B0, req_A1, req_B1;
    logic [3:0]  req_func0, req_func1;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [15:0] resp_C;
    logic [15:0] alu_A, alu_B, alu_C;
    logic [3:0]  alu_func;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int ready_both = 0;
    int resp_both = 0;
    int resp_pulses = 0;

    alu_share_arbiter #(.data_width(16), .func_width(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A0(req_A0), .req_B0(req_B0), .req_func0(req_func0),
        .req_A1(req_A1), .req_B1(req_B1), .req_func1(req_func1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_C(resp_C),
        .alu_A(alu_A), .alu_B(alu_B), .alu_func(alu_func), .alu_C(alu_C),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_func)
            F_AND:   alu_C = alu_A & alu_B;
            F_OR:    alu_C = alu_A | alu_B;
            F_XOR:   alu_C = alu_A ^ alu_B;
            F_ADD:   alu_C = alu_A + alu_B;
            default: alu_C = 16'h0000;
        endcase
    end

    always @(negedge clk) begin
        if (req_ready == 2'b11) ready_both++;
        if (resp_valid == 2'b11) resp_both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] a0, b0;
        logic [3:0]  f0;
        logic [15:0] a1, b1;
        logic [3:0]  f1;
        logic        g;
        logic [15:0] c;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{2'b11, 16'hFFFF, 16'h00FF, F_XOR, 16'h1200, 16'h0034, F_OR,  1'b0, 16'hFF00};
        vecs[1] = '{2'b11, 16'hFFFF, 16'h00FF, F_XOR, 16'h1200, 16'h0034, F_OR,  1'b1, 16'h1234};
        vecs[2] = '{2'b11, 16'h0001, 16'h0002, F_ADD, 16'hF0F0, 16'hFF00, F_AND, 1'b0, 16'h0003};
        vecs[3] = '{2'b11, 16'h0001, 16'h0002, F_ADD, 16'hF0F0, 16'hFF00, F_AND, 1'b1, 16'hF000};
        vecs[4] = '{2'b11, 16'h8000, 16'h0001, F_OR,  16'hFFFF, 16'h0001, F_ADD, 1'b0, 16'h8001};
        vecs[5] = '{2'b11, 16'h8000, 16'h0001, F_OR,  16'hFFFF, 16'h0001, F_ADD, 1'b1, 16'h0000};
        vecs[6] = '{2'b10, 16'h0000, 16'h0000, F_AND, 16'hAAAA, 16'h5555, F_XOR, 1'b1, 16'hFFFF};
        vecs[7] = '{2'b01, 16'h00F0, 16'h0FF0, F_AND, 16'h0000, 16'h0000, F_AND, 1'b0, 16'h00F0};
        vecs[8] = '{2'b10, 16'h0000, 16'h0000, F_AND, 16'h7FFF, 16'h0001, F_ADD, 1'b1, 16'h8000};

        reset_n = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b00;
        req_A0 = '0; req_B0 = '0; req_func0 = '0;
        req_A1 = '0; req_B1 = '0; req_func1 = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_alu_A", alu_A, 0);
        check("rst_alu_B", alu_B, 0);
        check("rst_alu_func", alu_func, 0);
        check("rst_resp_C", resp_C, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Contention, fairness and single-requester vectors, back to back.
        for (int i = 0; i < 9; i++) begin
            req_valid = vecs[i].valid;
            req_A0 = vecs[i].a0; req_B0 = vecs[i].b0; req_func0 = vecs[i].f0;
            req_A1 = vecs[i].a1; req_B1 = vecs[i].b1; req_func1 = vecs[i].f1;
            resp_ready = 2'b11;
            #1;
            check("vec_req_ready", req_ready, vecs[i].g ? 2'b10 : 2'b01);
            @(negedge clk);
            check("vec_exec_busy", busy, 1);
            check("vec_exec_resp_valid", resp_valid, 0);
            check("vec_alu_A", alu_A, vecs[i].g ? vecs[i].a1 : vecs[i].a0);
            check("vec_alu_func", alu_func, vecs[i].g ? vecs[i].f1 : vecs[i].f0);
            @(negedge clk);
            check("vec_resp_valid", resp_valid, vecs[i].g ? 2'b10 : 2'b01);
            check("vec_resp_C", resp_C, vecs[i].c);
            check("vec_resp_req_ready", req_ready, 0);
            @(negedge clk);
            check("vec_idle_busy", busy, 0);
            check("vec_idle_resp_valid", resp_valid, 0);
        end
        req_valid = 2'b00;

        // Backpressure on r1 while r0 waits; non-owner resp_ready must be ignored.
        req_valid = 2'b10;
        req_A1 = 16'h00FF; req_B1 = 16'h0F0F; req_func1 = F_XOR;
        resp_ready = 2'b00;
        #1;
        check("bp_req_ready_r1", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b11;
        req_A0 = 16'h0001; req_B0 = 16'h0002; req_func0 = F_ADD;
        resp_ready = 2'b01;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid", resp_valid, 2'b10);
            check("bp_resp_C", resp_C, 16'h0FF0);
            check("bp_req_ready", req_ready, 2'b00);
            check("bp_busy", busy, 1);
            @(negedge clk);
        end
        resp_ready = 2'b10;
        #1;
        check("bp_hold_resp_valid", resp_valid, 2'b10);
        @(negedge clk);
        check("bp_r0_granted", req_ready, 2'b01);
        resp_ready = 2'b11;
        @(negedge clk);
        check("bp_r0_busy", busy, 1);
        check("bp_r0_alu_A", alu_A, 16'h0001);
        req_valid = 2'b00;
        @(negedge clk);
        check("bp_r0_resp_valid", resp_valid, 2'b01);
        check("bp_r0_resp_C", resp_C, 16'h0003);
        @(negedge clk);
        check("bp_r0_idle", busy, 0);

        // Requester inputs change right after accept.
        req_valid = 2'b01;
        req_A0 = 16'h1111; req_B0 = 16'h0101; req_func0 = F_XOR;
        #1;
        check("chg_req_ready", req_ready, 2'b01);
        @(negedge clk);
        req_A0 = 16'hFFFF; req_B0 = 16'h0000; req_func0 = F_OR;
        req_valid = 2'b00;
        #1;
        check("chg_alu_A", alu_A, 16'h1111);
        check("chg_alu_B", alu_B, 16'h0101);
        check("chg_alu_func", alu_func, F_XOR);
        @(negedge clk);
        check("chg_resp_C", resp_C, 16'h1010);
        @(negedge clk);
        check("chg_idle", busy, 0);

        // prio is now 1; reset during EXEC must abort and clear it.
        req_valid = 2'b11;
        req_A1 = 16'h5555; req_B1 = 16'hAAAA; req_func1 = F_OR;
        #1;
        check("mid_prio1_grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        check("mid_exec_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_alu_A", alu_A, 0);
        check("mid_rst_alu_B", alu_B, 0);
        check("mid_rst_alu_func", alu_func, 0);
        check("mid_rst_resp_C", resp_C, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) resp_pulses++;
        end
        check("mid_no_resp_pulse", resp_pulses, 0);
        check("mid_idle_busy", busy, 0);
        req_valid = 2'b11;
        #1;
        check("mid_prio0_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);

        check("req_ready_onehot", ready_both, 0);
        check("resp_valid_onehot", resp_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
